// File: rtl/axi_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_fifo
//  Description : Single-clock AXI4-Stream FIFO. Beats accepted on s_* are
//                replayed unchanged and in order on m_*. Also reports the
//                stored beat count and the stored end-of-packet count.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_fifo #(
  parameter int BYTE_WIDTH = 4,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [8*BYTE_WIDTH-1:0] s_tdata,
  input  logic [BYTE_WIDTH-1:0]   s_tstrb,
  input  logic [BYTE_WIDTH-1:0]   s_tkeep,
  input  logic                    s_tlast,
  input  logic [ID_WIDTH-1:0]     s_tid,
  input  logic [DEST_WIDTH-1:0]   s_tdest,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [8*BYTE_WIDTH-1:0] m_tdata,
  output logic [BYTE_WIDTH-1:0]   m_tstrb,
  output logic [BYTE_WIDTH-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic [ID_WIDTH-1:0]     m_tid,
  output logic [DEST_WIDTH-1:0]   m_tdest,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic [DEPTH_LOG2:0]     level,
  output logic [DEPTH_LOG2:0]     packets
);

  localparam int c_PW    = 8*BYTE_WIDTH + 2*BYTE_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  // Storage is deliberately left unreset; only pointers and counters clear.
  logic [c_PW-1:0]       mem_q [c_DEPTH];

  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DEPTH_LOG2:0]   packets_q, packets_d;
  logic                  s_tready_q, s_tready_d;

  logic                  w_push;
  logic                  w_pop;
  logic [c_PW-1:0]       w_s_beat;
  logic [c_PW-1:0]       w_head;

  assign w_s_beat = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
  assign w_head   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // Head entry is never overwritten while occupied, so m_* is stable on a stall.
  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = w_head;

  assign m_tvalid = (wr_ptr_q != rd_ptr_q);
  assign s_tready = s_tready_q;
  assign level    = level_q;
  assign packets  = packets_q;

  // s_tready is a register, so a full FIFO cannot accept in its pop cycle.
  assign w_push = s_tvalid && s_tready_q;
  assign w_pop  = m_tvalid && m_tready;

  // Write the incoming beat into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= w_s_beat;
    end
  end

  // Next pointers, counters and the registered ready (full look-ahead).
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    packets_d = packets_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_ONE;
    end

    if (w_push && !w_pop) begin
      level_d = level_q + c_ONE;
    end else if (!w_push && w_pop) begin
      level_d = level_q - c_ONE;
    end

    if ((w_push && s_tlast) && !(w_pop && m_tlast)) begin
      packets_d = packets_q + c_ONE;
    end else if (!(w_push && s_tlast) && (w_pop && m_tlast)) begin
      packets_d = packets_q - c_ONE;
    end

    // Full when the pointers differ only in the wrap bit.
    s_tready_d = (wr_ptr_d != {~rd_ptr_d[DEPTH_LOG2], rd_ptr_d[DEPTH_LOG2-1:0]});
  end

  // State registers; reset clears everything except the storage array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      packets_q  <= '0;
      s_tready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      packets_q  <= packets_d;
      s_tready_q <= s_tready_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_stream_fifo
//  Description : Directed and randomized self-checking bench for
//                axi_stream_fifo (BYTE_WIDTH=4, DEPTH_LOG2=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_fifo;

  logic        clk;
  logic        reset;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic [3:0]  s_tkeep;
  logic        s_tlast;
  logic [0:0]  s_tid;
  logic [0:0]  s_tdest;
  logic [0:0]  s_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic [0:0]  m_tid;
  logic [0:0]  m_tdest;
  logic [0:0]  m_tuser;
  logic [2:0]  level;
  logic [2:0]  packets;

  int checks   = 0;
  int failures = 0;

  axi_stream_fifo #(
    .BYTE_WIDTH(4),
    .ID_WIDTH  (1),
    .DEST_WIDTH(1),
    .USER_WIDTH(1),
    .DEPTH_LOG2(2)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tstrb (s_tstrb),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .s_tid   (s_tid),
    .s_tdest (s_tdest),
    .s_tuser (s_tuser),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tstrb (m_tstrb),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_tid   (m_tid),
    .m_tdest (m_tdest),
    .m_tuser (m_tuser),
    .level   (level),
    .packets (packets)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    s_tstrb  = d[3:0];
    s_tkeep  = ~d[3:0];
    s_tid    = d[4];
    s_tdest  = d[5];
    s_tuser  = d[6];
  endtask

  function automatic logic [43:0] pack_s();
    return {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
  endfunction

  function automatic logic [43:0] pack_m();
    return {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
  endfunction

  logic [43:0] sb[$];
  logic [43:0] held_m;
  logic        stalled;
  logic        p_push, p_pop;
  int          pkt_model;
  logic [31:0] rnd;

  initial begin
    reset    = 1'b1;
    m_tready = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #2;
    chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_level",    {61'd0, level},    64'd0);
    chk("rst_packets",  {61'd0, packets},  64'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_s_tready", {63'd0, s_tready}, 64'd1);

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h11 * (i + 1), (i == 3));
      step();
      chk("fill_level", {61'd0, level}, 64'(i + 1));
      chk("fill_head",  {32'd0, m_tdata}, 64'h11);
    end
    chk("full_packets",  {61'd0, packets},  64'd1);
    chk("full_s_tready", {63'd0, s_tready}, 64'd0);
    chk("head_strb",     {60'd0, m_tstrb},  64'h1);
    chk("head_keep",     {60'd0, m_tkeep},  64'he);
    chk("head_tid",      {63'd0, m_tid},    64'd1);
    chk("head_tdest",    {63'd0, m_tdest},  64'd0);

    // Fifth beat is held by the producer and not taken.
    drive(1'b1, 32'h55, 1'b0);
    step();
    chk("held_level", {61'd0, level},   64'd4);
    chk("held_head",  {32'd0, m_tdata}, 64'h11);

    // Release the consumer: ready returns one edge after the pop.
    m_tready = 1'b1;
    step();
    chk("popN_s_tready", {63'd0, s_tready}, 64'd1);
    chk("popN_level",    {61'd0, level},    64'd3);
    chk("popN_head",     {32'd0, m_tdata},  64'h22);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk("popN1_level", {61'd0, level},   64'd3);
    chk("popN1_head",  {32'd0, m_tdata}, 64'h33);
    step();
    chk("drain_head44",  {32'd0, m_tdata}, 64'h44);
    chk("drain_last44",  {63'd0, m_tlast}, 64'd1);
    step();
    chk("drain_head55",  {32'd0, m_tdata}, 64'h55);
    chk("drain_packets", {61'd0, packets}, 64'd0);
    step();
    chk("drain_empty", {63'd0, m_tvalid}, 64'd0);
    chk("drain_level", {61'd0, level},    64'd0);

    // Steady simultaneous push/pop at level 2 across pointer wrap.
    m_tready = 1'b0;
    drive(1'b1, 32'hA0, 1'b0);
    step();
    drive(1'b1, 32'hA1, 1'b0);
    step();
    m_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'hA2 + k, 1'b0);
      chk("pp_head", {32'd0, m_tdata}, 64'(32'hA0 + k));
      step();
      chk("pp_level", {61'd0, level}, 64'd2);
    end
    drive(1'b0, 32'h0, 1'b0);
    chk("pp_tail0", {32'd0, m_tdata}, 64'hAA);
    step();
    chk("pp_tail1", {32'd0, m_tdata}, 64'hAB);
    step();
    chk("pp_empty", {63'd0, m_tvalid}, 64'd0);

    // Single beat into an empty FIFO: visible one edge later.
    m_tready = 1'b0;
    drive(1'b1, 32'h77, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk("one_valid",   {63'd0, m_tvalid}, 64'd1);
    chk("one_data",    {32'd0, m_tdata},  64'h77);
    chk("one_level",   {61'd0, level},    64'd1);
    chk("one_packets", {61'd0, packets},  64'd1);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    chk("one_pop_valid",   {63'd0, m_tvalid}, 64'd0);
    chk("one_pop_level",   {61'd0, level},    64'd0);
    chk("one_pop_packets", {61'd0, packets},  64'd0);

    // Asynchronous reset in the middle of a packet.
    drive(1'b1, 32'h81, 1'b1);
    step();
    drive(1'b1, 32'h82, 1'b0);
    step();
    drive(1'b1, 32'h83, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk("mid_level",   {61'd0, level},   64'd3);
    chk("mid_packets", {61'd0, packets}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("arst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("arst_level",    {61'd0, level},    64'd0);
    chk("arst_packets",  {61'd0, packets},  64'd0);
    step();
    reset = 1'b0;
    step();
    chk("arst_rel_s_tready", {63'd0, s_tready}, 64'd1);
    chk("arst_rel_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("arst_rel_level",    {61'd0, level},    64'd0);

    // Random traffic with scoreboard and stream-master monitor.
    pkt_model = 0;
    stalled   = 1'b0;
    held_m    = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!(s_tvalid && !s_tready)) begin
        rnd = $urandom;
        drive(($urandom_range(0, 3) != 0), rnd, rnd[7]);
      end
      m_tready = ($urandom_range(0, 2) != 0);
      #1;
      if (stalled) begin
        chk("mon_valid_hold", {63'd0, m_tvalid}, 64'd1);
        chk("mon_payload_hold", {20'd0, pack_m()}, {20'd0, held_m});
      end
      chk("rnd_m_tvalid", {63'd0, m_tvalid}, {63'd0, (sb.size() != 0)});
      p_push = s_tvalid && s_tready;
      p_pop  = m_tvalid && m_tready;
      if (p_pop && sb.size() != 0) begin
        chk("rnd_data", {20'd0, pack_m()}, {20'd0, sb[0]});
        if (sb[0][3]) pkt_model--;
        void'(sb.pop_front());
      end
      if (p_push) begin
        sb.push_back(pack_s());
        if (s_tlast) pkt_model++;
      end
      stalled = m_tvalid && !m_tready;
      held_m  = pack_m();
      step();
      chk("rnd_level",   {61'd0, level},   64'(sb.size()));
      chk("rnd_packets", {61'd0, packets}, 64'(pkt_model));
      chk("rnd_level_max", {63'd0, (level <= 3'd4)}, 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
